// File: rtl/rs_pkg.sv
// Shared types and sizing constants for the ALU reservation station.
package rs_pkg;

  localparam int RS_N      = 4;
  localparam int RS_TAG_W  = 3;
  localparam int RS_OP_W   = 32;
  localparam int RS_CTRL_W = 4;

  typedef struct packed {
    logic [RS_OP_W-1:0]  value;
    logic                ready;
    logic [RS_TAG_W-1:0] tag;
  } rs_opnd_t;

  typedef struct packed {
    logic [RS_CTRL_W-1:0] ctrl;
    logic [RS_TAG_W-1:0]  rob_dest;
    rs_opnd_t             op1;
    rs_opnd_t             op2;
  } rs_entry_t;

  // Capture a CDB broadcast into an operand still waiting on that tag.
  function automatic rs_opnd_t rs_wake(rs_opnd_t o, logic cdb_valid,
                                       logic [RS_TAG_W-1:0] cdb_tag,
                                       logic [RS_OP_W-1:0] cdb_value);
    rs_wake = o;
    if (!o.ready && cdb_valid && (o.tag == cdb_tag)) begin
      rs_wake.value = cdb_value;
      rs_wake.ready = 1'b1;
    end
  endfunction

endpackage

// File: rtl/alu_reservation_station_if.sv
// Dispatch, CDB, flush and issue-slot signals of the ALU reservation station.
interface alu_reservation_station_if
  import rs_pkg::*;
#(
  parameter int WIDTH   = RS_OP_W - 1,
  parameter int A_WIDTH = RS_CTRL_W - 1,
  parameter int ROB     = RS_TAG_W - 1,
  parameter int ALU     = RS_N - 1
);
  logic [ALU:0]     ALURequests;
  logic [WIDTH:0]   value1, value2;
  logic             ready1, ready2;
  logic [ROB:0]     rob1, rob2, robDest;
  logic [A_WIDTH:0] aluCntrl;
  logic             cdbValid;
  logic [ROB:0]     cdbTag;
  logic [WIDTH:0]   cdbValue;
  logic             flush;
  logic             issueReady;
  logic             issueValid;
  logic [WIDTH:0]   issueOp1, issueOp2;
  logic [A_WIDTH:0] issueCntrl;
  logic [ROB:0]     issueRob;
  logic [ALU:0]     ALUBusyVector;
  logic             ALUFull;

  modport master (
    output ALURequests, value1, value2, ready1, ready2, rob1, rob2, robDest,
           aluCntrl, cdbValid, cdbTag, cdbValue, flush, issueReady,
    input  issueValid, issueOp1, issueOp2, issueCntrl, issueRob,
           ALUBusyVector, ALUFull
  );

  modport slave (
    input  ALURequests, value1, value2, ready1, ready2, rob1, rob2, robDest,
           aluCntrl, cdbValid, cdbTag, cdbValue, flush, issueReady,
    output issueValid, issueOp1, issueOp2, issueCntrl, issueRob,
           ALUBusyVector, ALUFull
  );
endinterface

// File: rtl/rs_age_matrix.sv
// Older-than matrix picking the oldest eligible entry; built only with ALU_RS_AGE_EN.
module rs_age_matrix #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] alloc,
  input  logic [N-1:0] free,
  input  logic [N-1:0] busy,
  input  logic         flush,
  input  logic [N-1:0] eligible,
  output logic [N-1:0] grant
);
  // older[i][j] = 1: entry j was allocated before entry i
  logic [N-1:0] older [N];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < N; r++) older[r] <= '0;
    end else if (flush) begin
      for (int r = 0; r < N; r++) older[r] <= '0;
    end else begin
      for (int r = 0; r < N; r++) begin
        if (alloc[r]) older[r] <= busy & ~free;
        else          older[r] <= older[r] & ~free;
      end
    end
  end

  always_comb begin
    grant = '0;
    for (int i = 0; i < N; i++)
      grant[i] = eligible[i] & ~|(older[i] & eligible);
  end
endmodule

// File: rtl/alu_reservation_station.sv
// Four-entry ALU reservation station with CDB wakeup and a registered issue slot.
// ALU_RS_AGE_EN: oldest-first selection via rs_age_matrix; otherwise lowest index wins.
module alu_reservation_station
  import rs_pkg::*;
#(
  parameter int WIDTH   = RS_OP_W - 1,
  parameter int A_WIDTH = RS_CTRL_W - 1,
  parameter int ROB     = RS_TAG_W - 1,
  parameter int ALU     = RS_N - 1
) (
  input logic                      clk,
  input logic                      reset,
  alu_reservation_station_if.slave rs
);
  logic [ALU:0]     busy, alloc, eligible, grant, free;
  rs_entry_t        ent [ALU+1];
  rs_entry_t        ent_new, sel_ent;
  logic             issue_valid, load;
  logic [WIDTH:0]   issue_op1, issue_op2;
  logic [A_WIDTH:0] issue_cntrl;
  logic [ROB:0]     issue_rob;

  assign alloc = rs.ALURequests & ~busy;

  // Same-cycle bypass so an operand whose producer broadcasts now is not missed.
  always_comb begin
    ent_new          = '0;
    ent_new.ctrl     = rs.aluCntrl;
    ent_new.rob_dest = rs.robDest;
    ent_new.op1      = rs_wake('{value: rs.value1, ready: rs.ready1, tag: rs.rob1},
                               rs.cdbValid, rs.cdbTag, rs.cdbValue);
    ent_new.op2      = rs_wake('{value: rs.value2, ready: rs.ready2, tag: rs.rob2},
                               rs.cdbValid, rs.cdbTag, rs.cdbValue);
  end

  always_comb begin
    eligible = '0;
    for (int i = 0; i <= ALU; i++)
      eligible[i] = busy[i] & ent[i].op1.ready & ent[i].op2.ready;
  end

`ifdef ALU_RS_AGE_EN
  rs_age_matrix #(.N(ALU + 1)) u_age (
    .clk      (clk),
    .reset    (reset),
    .alloc    (alloc),
    .free     (free),
    .busy     (busy),
    .flush    (rs.flush),
    .eligible (eligible),
    .grant    (grant)
  );
`else
  assign grant = eligible & (-eligible);
`endif

  assign load = (|eligible) & (~issue_valid | rs.issueReady);
  assign free = load ? grant : '0;

  always_comb begin
    sel_ent = '0;
    for (int i = 0; i <= ALU; i++)
      if (grant[i]) sel_ent = ent[i];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy <= '0;
      for (int i = 0; i <= ALU; i++) ent[i] <= '0;
    end else if (rs.flush) begin
      busy <= '0;
    end else begin
      for (int i = 0; i <= ALU; i++) begin
        if (alloc[i]) begin
          ent[i]  <= ent_new;
          busy[i] <= 1'b1;
        end else begin
          if (free[i]) busy[i] <= 1'b0;
          if (busy[i]) begin
            ent[i].op1 <= rs_wake(ent[i].op1, rs.cdbValid, rs.cdbTag, rs.cdbValue);
            ent[i].op2 <= rs_wake(ent[i].op2, rs.cdbValid, rs.cdbTag, rs.cdbValue);
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      issue_valid <= 1'b0;
      issue_op1   <= '0;
      issue_op2   <= '0;
      issue_cntrl <= '0;
      issue_rob   <= '0;
    end else if (rs.flush) begin
      issue_valid <= 1'b0;
    end else if (load) begin
      issue_valid <= 1'b1;
      issue_op1   <= sel_ent.op1.value;
      issue_op2   <= sel_ent.op2.value;
      issue_cntrl <= sel_ent.ctrl;
      issue_rob   <= sel_ent.rob_dest;
    end else if (rs.issueReady) begin
      issue_valid <= 1'b0;
    end
  end

  assign rs.issueValid    = issue_valid;
  assign rs.issueOp1      = issue_op1;
  assign rs.issueOp2      = issue_op2;
  assign rs.issueCntrl    = issue_cntrl;
  assign rs.issueRob      = issue_rob;
  assign rs.ALUBusyVector = busy;
  assign rs.ALUFull       = &busy;

  a_req_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(rs.ALURequests));
endmodule

// File: tb/tb_alu_reservation_station.sv
// Directed bench for alu_reservation_station: dispatch, wakeup, bypass, full, age order, flush, reset.
module tb_alu_reservation_station;
  import rs_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_pass = 0;
  int   n_total = 0;

  alu_reservation_station_if rif ();

  alu_reservation_station dut (
    .clk   (clk),
    .reset (reset),
    .rs    (rif)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic dispatch(input logic [3:0] req, input logic [31:0] v1, input logic [31:0] v2,
                          input logic r1, input logic r2, input logic [2:0] t1,
                          input logic [2:0] t2, input logic [2:0] dst, input logic [3:0] ctl);
    rif.ALURequests = req;
    rif.value1      = v1;
    rif.value2      = v2;
    rif.ready1      = r1;
    rif.ready2      = r2;
    rif.rob1        = t1;
    rif.rob2        = t2;
    rif.robDest     = dst;
    rif.aluCntrl    = ctl;
  endtask

  task automatic cdb(input logic v, input logic [2:0] t, input logic [31:0] d);
    rif.cdbValid = v;
    rif.cdbTag   = t;
    rif.cdbValue = d;
  endtask

  initial begin
    dispatch(4'b0000, 0, 0, 0, 0, 0, 0, 0, 0);
    cdb(1'b0, 0, 0);
    rif.flush      = 1'b0;
    rif.issueReady = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    chk("rst_busy", rif.ALUBusyVector, 4'b0000);
    chk("rst_full", rif.ALUFull, 0);
    chk("rst_valid", rif.issueValid, 0);
    chk("rst_op1", rif.issueOp1, 0);

    // Basic ready dispatch
    rif.issueReady = 1'b1;
    dispatch(4'b0001, 5, 7, 1, 1, 0, 0, 3, 2);
    tick();
    rif.ALURequests = 4'b0000;
    chk("t1_busy", rif.ALUBusyVector, 4'b0001);
    chk("t1_valid0", rif.issueValid, 0);
    tick();
    chk("t1_valid", rif.issueValid, 1);
    chk("t1_op1", rif.issueOp1, 5);
    chk("t1_op2", rif.issueOp2, 7);
    chk("t1_rob", rif.issueRob, 3);
    chk("t1_ctl", rif.issueCntrl, 2);
    chk("t1_busy_clr", rif.ALUBusyVector, 4'b0000);
    tick();
    chk("t1_drain", rif.issueValid, 0);

    // CDB wakeup of operand 2
    dispatch(4'b0010, 9, 0, 1, 0, 0, 4, 1, 3);
    tick();
    rif.ALURequests = 4'b0000;
    chk("t2_busy", rif.ALUBusyVector, 4'b0010);
    tick();
    chk("t2_wait", rif.issueValid, 0);
    cdb(1'b1, 4, 32'h1234);
    tick();
    cdb(1'b0, 0, 0);
    chk("t2_wake_lat", rif.issueValid, 0);
    tick();
    chk("t2_valid", rif.issueValid, 1);
    chk("t2_op2", rif.issueOp2, 32'h1234);
    chk("t2_op1", rif.issueOp1, 9);
    chk("t2_busy_clr", rif.ALUBusyVector, 4'b0000);
    tick();
    chk("t2_drain", rif.issueValid, 0);

    // Same-cycle bypass on allocation
    dispatch(4'b0100, 0, 32'h22, 0, 1, 6, 0, 4, 1);
    cdb(1'b1, 6, 32'habc);
    tick();
    rif.ALURequests = 4'b0000;
    cdb(1'b0, 0, 0);
    chk("t3_busy", rif.ALUBusyVector, 4'b0100);
    tick();
    chk("t3_valid", rif.issueValid, 1);
    chk("t3_op1", rif.issueOp1, 32'habc);
    chk("t3_op2", rif.issueOp2, 32'h22);
    chk("t3_rob", rif.issueRob, 4);
    tick();
    chk("t3_drain", rif.issueValid, 0);

    // Fill with the slot stalled
    rif.issueReady = 1'b0;
    dispatch(4'b0001, 32'h10, 0, 1, 1, 0, 0, 0, 0);
    tick();
    dispatch(4'b0010, 32'h11, 0, 1, 1, 0, 0, 1, 0);
    tick();
    chk("t4_slot_rob", rif.issueRob, 0);
    chk("t4_slot_valid", rif.issueValid, 1);
    chk("t4_busy_a", rif.ALUBusyVector, 4'b0010);
    dispatch(4'b0100, 32'h12, 0, 1, 1, 0, 0, 2, 0);
    tick();
    dispatch(4'b1000, 32'h13, 0, 1, 1, 0, 0, 3, 0);
    tick();
    dispatch(4'b0001, 32'h50, 0, 1, 1, 0, 0, 5, 0);
    tick();
    chk("t4_full", rif.ALUFull, 1);
    chk("t4_busy_full", rif.ALUBusyVector, 4'b1111);
    chk("t4_hold_rob", rif.issueRob, 0);
    dispatch(4'b0010, 32'hdead, 0, 1, 1, 0, 0, 7, 0);
    tick();
    rif.ALURequests = 4'b0000;
    chk("t4_ignore_busy", rif.ALUBusyVector, 4'b1111);
    chk("t4_hold_rob2", rif.issueRob, 0);
    chk("t4_hold_op1", rif.issueOp1, 32'h10);
    chk("t4_hold_valid", rif.issueValid, 1);
    rif.issueReady = 1'b1;
    tick();
    rif.issueReady = 1'b0;
`ifdef ALU_RS_AGE_EN
    chk("t4_next_rob", rif.issueRob, 1);
    chk("t4_next_op1", rif.issueOp1, 32'h11);
    chk("t4_one_drained", rif.ALUBusyVector, 4'b1101);
`else
    chk("t4_next_rob", rif.issueRob, 5);
    chk("t4_next_op1", rif.issueOp1, 32'h50);
    chk("t4_one_drained", rif.ALUBusyVector, 4'b1110);
`endif
    chk("t4_not_full", rif.ALUFull, 0);
    tick();
`ifdef ALU_RS_AGE_EN
    chk("t4_stable_rob", rif.issueRob, 1);
    chk("t4_stable_busy", rif.ALUBusyVector, 4'b1101);
`else
    chk("t4_stable_rob", rif.issueRob, 5);
    chk("t4_stable_busy", rif.ALUBusyVector, 4'b1110);
`endif

    // Flush with three busy entries and a full slot
    rif.flush = 1'b1;
    tick();
    rif.flush = 1'b0;
    chk("t5_busy", rif.ALUBusyVector, 4'b0000);
    chk("t5_valid", rif.issueValid, 0);
    chk("t5_full", rif.ALUFull, 0);

    // Selection order: entry2 allocated before entry0, both woken together
    dispatch(4'b0100, 0, 2, 0, 1, 5, 0, 2, 0);
    tick();
    dispatch(4'b0001, 0, 0, 0, 1, 5, 0, 0, 0);
    tick();
    rif.ALURequests = 4'b0000;
    chk("t6_busy", rif.ALUBusyVector, 4'b0101);
    cdb(1'b1, 5, 32'h77);
    tick();
    cdb(1'b0, 0, 0);
    tick();
    chk("t6_valid", rif.issueValid, 1);
    chk("t6_op1", rif.issueOp1, 32'h77);
`ifdef ALU_RS_AGE_EN
    chk("t6_first_rob", rif.issueRob, 2);
`else
    chk("t6_first_rob", rif.issueRob, 0);
`endif
    rif.issueReady = 1'b1;
    tick();
`ifdef ALU_RS_AGE_EN
    chk("t6_second_rob", rif.issueRob, 0);
`else
    chk("t6_second_rob", rif.issueRob, 2);
`endif
    tick();
    chk("t6_drain", rif.issueValid, 0);
    chk("t6_busy_clr", rif.ALUBusyVector, 4'b0000);

    // Reset in the middle of an issue handshake
    rif.issueReady = 1'b0;
    dispatch(4'b0001, 32'h33, 32'h44, 1, 1, 0, 0, 6, 1);
    tick();
    dispatch(4'b0010, 32'h55, 32'h66, 1, 1, 0, 0, 7, 1);
    tick();
    rif.ALURequests = 4'b0000;
    chk("t7_pre_valid", rif.issueValid, 1);
    chk("t7_pre_busy", rif.ALUBusyVector, 4'b0010);
    rif.issueReady = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    chk("t7_valid", rif.issueValid, 0);
    chk("t7_busy", rif.ALUBusyVector, 4'b0000);
    chk("t7_op1", rif.issueOp1, 0);
    chk("t7_rob", rif.issueRob, 0);
    chk("t7_full", rif.ALUFull, 0);
    tick();
    reset = 1'b0;
    tick();
    chk("t7_after_valid", rif.issueValid, 0);
    chk("t7_after_busy", rif.ALUBusyVector, 4'b0000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
